// File: rtl/cordic_arbiter_if.sv
// Requester and CORDIC-core signal bundle for cordic_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface cordic_arbiter_if #(
  parameter int p_WIDTH = 32
);
  logic [1:0]           reqValid;
  logic [1:0]           reqReady;
  logic [2*p_WIDTH-1:0] reqX;
  logic [2*p_WIDTH-1:0] reqY;
  logic [2*p_WIDTH-1:0] reqZ;
  logic [2*p_WIDTH-1:0] reqControl;
  logic [1:0]           rspValid;
  logic [p_WIDTH-1:0]   rspX;
  logic [p_WIDTH-1:0]   rspY;
  logic [p_WIDTH-1:0]   rspZ;
  logic [p_WIDTH-1:0]   rspControl;
  logic                 rspError;
  logic [p_WIDTH-1:0]   coreX;
  logic [p_WIDTH-1:0]   coreY;
  logic [p_WIDTH-1:0]   coreZ;
  logic [p_WIDTH-1:0]   coreControl;
  logic [p_WIDTH-1:0]   coreXResult;
  logic [p_WIDTH-1:0]   coreYResult;
  logic [p_WIDTH-1:0]   coreZResult;
  logic [p_WIDTH-1:0]   coreControlResult;
  logic                 coreInterrupt;
  logic                 busy;
  logic                 grantId;

  modport slave (
    input  reqValid, reqX, reqY, reqZ, reqControl,
    input  coreXResult, coreYResult, coreZResult, coreControlResult, coreInterrupt,
    output reqReady, rspValid, rspX, rspY, rspZ, rspControl, rspError,
    output coreX, coreY, coreZ, coreControl, busy, grantId
  );

  modport master (
    output reqValid, reqX, reqY, reqZ, reqControl,
    output coreXResult, coreYResult, coreZResult, coreControlResult, coreInterrupt,
    input  reqReady, rspValid, rspX, rspY, rspZ, rspControl, rspError,
    input  coreX, coreY, coreZ, coreControl, busy, grantId
  );
endinterface

// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for a single CORDIC core.
// Optional WAIT-state watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
  parameter int p_WIDTH   = 32,
  parameter int p_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  cordic_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               last_grant_r;
  logic               grant_r;
  logic [p_WIDTH-1:0] cap_x_r;
  logic [p_WIDTH-1:0] cap_y_r;
  logic [p_WIDTH-1:0] cap_z_r;
  logic [p_WIDTH-1:0] cap_ctrl_r;
  logic [p_WIDTH-1:0] rsp_x_r;
  logic [p_WIDTH-1:0] rsp_y_r;
  logic [p_WIDTH-1:0] rsp_z_r;
  logic [p_WIDTH-1:0] rsp_ctrl_r;
  logic               sel_s;
  logic [1:0]         ready_s;
  logic               accept_s;
  logic               done_s;
  logic               timeout_s;
  logic [p_WIDTH-1:0] core_ctrl_s;

  if (p_TIMEOUT < 1) begin : g_timeout_range_chk
    $error("p_TIMEOUT must be at least 1");
  end

  // Requester selection: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    sel_s = 1'b0;
    case (bus.reqValid)
      2'b01:   sel_s = 1'b0;
      2'b10:   sel_s = 1'b1;
      2'b11:   sel_s = ~last_grant_r;
      default: sel_s = 1'b0;
    endcase
  end

  // Ready is offered only in IDLE, and never while reset is being applied.
  always_comb begin
    ready_s = 2'b00;
    if ((state_r == ST_IDLE) && !rst && (bus.reqValid != 2'b00)) begin
      ready_s = sel_s ? 2'b10 : 2'b01;
    end else begin
      ready_s = 2'b00;
    end
  end

  assign accept_s = |(bus.reqValid & ready_s);
  assign done_s   = (state_r == ST_WAIT) && bus.coreInterrupt;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(p_TIMEOUT + 1);

  logic [c_CNT_W-1:0] wait_cnt_r;
  logic               rsp_error_r;

  // WAIT-cycle counter, cleared during ISSUE so it starts at zero on WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {c_CNT_W{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      wait_cnt_r <= {c_CNT_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + {{(c_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // The last permitted WAIT cycle ends the job unless the interrupt arrives in it.
  assign timeout_s = (state_r == ST_WAIT) && !bus.coreInterrupt &&
                     (wait_cnt_r == c_CNT_W'(p_TIMEOUT - 1));

  // Error flag follows the most recent completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_error_r <= 1'b0;
    end else if (done_s) begin
      rsp_error_r <= 1'b0;
    end else if (timeout_s) begin
      rsp_error_r <= 1'b1;
    end else begin
      rsp_error_r <= rsp_error_r;
    end
  end

  assign bus.rspError = rsp_error_r;
`else
  assign timeout_s    = 1'b0;
  assign bus.rspError = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    state_s = accept_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   state_s = ST_WAIT;
      ST_WAIT: begin
        if (done_s || timeout_s) begin
          state_s = ST_RESPOND;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESPOND: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on the accepting handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r    <= 1'b0;
      cap_x_r    <= {p_WIDTH{1'b0}};
      cap_y_r    <= {p_WIDTH{1'b0}};
      cap_z_r    <= {p_WIDTH{1'b0}};
      cap_ctrl_r <= {p_WIDTH{1'b0}};
    end else if (accept_s) begin
      grant_r    <= sel_s;
      cap_x_r    <= sel_s ? bus.reqX[2*p_WIDTH-1:p_WIDTH]       : bus.reqX[p_WIDTH-1:0];
      cap_y_r    <= sel_s ? bus.reqY[2*p_WIDTH-1:p_WIDTH]       : bus.reqY[p_WIDTH-1:0];
      cap_z_r    <= sel_s ? bus.reqZ[2*p_WIDTH-1:p_WIDTH]       : bus.reqZ[p_WIDTH-1:0];
      cap_ctrl_r <= sel_s ? bus.reqControl[2*p_WIDTH-1:p_WIDTH] : bus.reqControl[p_WIDTH-1:0];
    end else begin
      grant_r    <= grant_r;
      cap_x_r    <= cap_x_r;
      cap_y_r    <= cap_y_r;
      cap_z_r    <= cap_z_r;
      cap_ctrl_r <= cap_ctrl_r;
    end
  end

  // Result capture; a timeout returns zeroed results.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_x_r    <= {p_WIDTH{1'b0}};
      rsp_y_r    <= {p_WIDTH{1'b0}};
      rsp_z_r    <= {p_WIDTH{1'b0}};
      rsp_ctrl_r <= {p_WIDTH{1'b0}};
    end else if (done_s) begin
      rsp_x_r    <= bus.coreXResult;
      rsp_y_r    <= bus.coreYResult;
      rsp_z_r    <= bus.coreZResult;
      rsp_ctrl_r <= bus.coreControlResult;
    end else if (timeout_s) begin
      rsp_x_r    <= {p_WIDTH{1'b0}};
      rsp_y_r    <= {p_WIDTH{1'b0}};
      rsp_z_r    <= {p_WIDTH{1'b0}};
      rsp_ctrl_r <= {p_WIDTH{1'b0}};
    end else begin
      rsp_x_r    <= rsp_x_r;
      rsp_y_r    <= rsp_y_r;
      rsp_z_r    <= rsp_z_r;
      rsp_ctrl_r <= rsp_ctrl_r;
    end
  end

  // Round-robin history, updated as the response is delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (state_r == ST_RESPOND) begin
      last_grant_r <= grant_r;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Start bit is asserted only during ISSUE; every captured control bit is otherwise passed through.
  always_comb begin
    core_ctrl_s = (cap_ctrl_r & {{(p_WIDTH-1){1'b1}}, 1'b0}) |
                  {{(p_WIDTH-1){1'b0}}, (state_r == ST_ISSUE)};
  end

  assign bus.reqReady    = ready_s;
  assign bus.rspValid    = (state_r != ST_RESPOND) ? 2'b00 : (grant_r ? 2'b10 : 2'b01);
  assign bus.rspX        = rsp_x_r;
  assign bus.rspY        = rsp_y_r;
  assign bus.rspZ        = rsp_z_r;
  assign bus.rspControl  = rsp_ctrl_r;
  assign bus.coreX       = cap_x_r;
  assign bus.coreY       = cap_y_r;
  assign bus.coreZ       = cap_z_r;
  assign bus.coreControl = core_ctrl_s;
  assign bus.busy        = (state_r != ST_IDLE);
  assign bus.grantId     = grant_r;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized self-checking bench for cordic_arbiter with a transaction-level arbiter model.
// Also exercises the watchdog when CORDIC_ARB_TIMEOUT_EN is defined.
module tb_cordic_arbiter;
  localparam int W  = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic         model_last;
  logic [W-1:0] op_x [2];
  logic [W-1:0] op_y [2];
  logic [W-1:0] op_z [2];
  logic [W-1:0] op_c [2];
  logic [1:0]   pending;

  cordic_arbiter_if #(.p_WIDTH(W)) bus ();

  cordic_arbiter #(.p_WIDTH(W), .p_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference selection: lone requester wins, contention goes to the one not served last.
  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  task automatic drive_ops();
    bus.reqX       = {op_x[1], op_x[0]};
    bus.reqY       = {op_y[1], op_y[0]};
    bus.reqZ       = {op_z[1], op_z[0]};
    bus.reqControl = {op_c[1], op_c[0]};
  endtask

  task automatic random_ops();
    for (int i = 0; i < 2; i++) begin
      op_x[i] = $urandom;
      op_y[i] = $urandom;
      op_z[i] = $urandom;
      op_c[i] = $urandom;
    end
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.reqValid      = 2'b00;
    bus.coreInterrupt = 1'b0;
    step();
    step();
    rst        = 1'b0;
    model_last = 1'b1;
  endtask

  // One complete job; the core answers after 'delay' silent WAIT cycles.
  task automatic run_job(input logic [1:0] valid, input int delay, input logic [W-1:0] rx,
                         input logic [W-1:0] ry, input logic [W-1:0] rz, input logic [W-1:0] rc,
                         input bit stray, output logic [1:0] keep);
    logic n;
    n = pick(valid, model_last);
    drive_ops();
    bus.reqValid = valid;
    #1;
    check_eq("ready_idle", bus.reqReady, n ? 2'b10 : 2'b01);
    step();
    keep         = valid;
    keep[n]      = 1'b0;
    bus.reqValid = keep;
    #1;
    check_eq("issue_grant", bus.grantId, n);
    check_eq("issue_busy", bus.busy, 1'b1);
    check_eq("issue_ready", bus.reqReady, 2'b00);
    check_eq("issue_x", bus.coreX, op_x[n]);
    check_eq("issue_y", bus.coreY, op_y[n]);
    check_eq("issue_z", bus.coreZ, op_z[n]);
    check_eq("issue_ctrl", bus.coreControl, op_c[n] | 32'h0000_0001);
    bus.coreInterrupt = stray;
    step();
    bus.coreInterrupt = 1'b0;
    #1;
    check_eq("wait_entry", bus.busy, 1'b1);
    for (int i = 0; i < delay; i++) begin
      check_eq("wait_ctrl", bus.coreControl, op_c[n] & 32'hFFFF_FFFE);
      check_eq("wait_rsp", bus.rspValid, 2'b00);
      check_eq("wait_ready", bus.reqReady, 2'b00);
      step();
    end
    check_eq("wait_x", bus.coreX, op_x[n]);
    bus.coreXResult       = rx;
    bus.coreYResult       = ry;
    bus.coreZResult       = rz;
    bus.coreControlResult = rc;
    bus.coreInterrupt     = 1'b1;
    step();
    bus.coreInterrupt = stray;
    #1;
    check_eq("rsp_valid", bus.rspValid, n ? 2'b10 : 2'b01);
    check_eq("rsp_x", bus.rspX, rx);
    check_eq("rsp_y", bus.rspY, ry);
    check_eq("rsp_z", bus.rspZ, rz);
    check_eq("rsp_ctrl", bus.rspControl, rc);
    check_eq("rsp_err", bus.rspError, 1'b0);
    model_last = n;
    step();
    bus.coreInterrupt     = 1'b0;
    bus.coreXResult       = $urandom;
    bus.coreControlResult = $urandom;
    #1;
    check_eq("idle_busy", bus.busy, 1'b0);
    check_eq("idle_rspv", bus.rspValid, 2'b00);
    check_eq("idle_hold_x", bus.rspX, rx);
    check_eq("idle_hold_c", bus.rspControl, rc);
  endtask

  initial begin
    logic [1:0] v;
    bus.reqValid          = 2'b00;
    bus.reqX              = '0;
    bus.reqY              = '0;
    bus.reqZ              = '0;
    bus.reqControl        = '0;
    bus.coreXResult       = '0;
    bus.coreYResult       = '0;
    bus.coreZResult       = '0;
    bus.coreControlResult = '0;
    bus.coreInterrupt     = 1'b0;
    do_reset();

    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_rspv", bus.rspValid, 2'b00);
    check_eq("rst_ready", bus.reqReady, 2'b00);
    check_eq("rst_grant", bus.grantId, 1'b0);
    check_eq("rst_ctrl", bus.coreControl, 32'h0);
    check_eq("rst_err", bus.rspError, 1'b0);

    // Single directed job from requester 0, interrupt five cycles after start.
    random_ops();
    op_x[0] = 32'h4000_0000;
    op_y[0] = 32'h0;
    op_z[0] = 32'h2000_0000;
    run_job(2'b01, 4, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 1'b0, pending);

    // Contention after reset: 0,1 then 0,1 again.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      random_ops();
      run_job(2'b11, 1, $urandom, $urandom, $urandom, $urandom, 1'b0, pending);
      check_eq("cont_first", bus.grantId, 1'b0);
      random_ops();
      run_job(pending, 2, $urandom, $urandom, $urandom, $urandom, 1'b0, pending);
      check_eq("cont_second", bus.grantId, 1'b1);
    end

    // Stray interrupt in IDLE.
    bus.reqValid      = 2'b00;
    bus.coreInterrupt = 1'b1;
    step();
    bus.coreInterrupt = 1'b0;
    #1;
    check_eq("stray_idle_busy", bus.busy, 1'b0);
    check_eq("stray_idle_rspv", bus.rspValid, 2'b00);

    // Stray interrupt in ISSUE and RESPOND, requester 1 held pending throughout.
    random_ops();
    run_job(2'b11, 3, $urandom, $urandom, $urandom, $urandom, 1'b1, pending);
    random_ops();
    run_job(pending, 0, $urandom, $urandom, $urandom, $urandom, 1'b0, pending);

    // Reset in the middle of WAIT, then a late interrupt.
    random_ops();
    drive_ops();
    bus.reqValid = 2'b01;
    step();
    bus.reqValid = 2'b00;
    step();
    step();
    rst = 1'b1;
    step();
    rst                   = 1'b0;
    model_last            = 1'b1;
    bus.coreXResult       = 32'hDEAD_BEEF;
    bus.coreControlResult = 32'h1234_5678;
    bus.coreInterrupt     = 1'b1;
    step();
    bus.coreInterrupt = 1'b0;
    #1;
    check_eq("abort_rspv", bus.rspValid, 2'b00);
    check_eq("abort_busy", bus.busy, 1'b0);
    check_eq("abort_rspx", bus.rspX, 32'h0);
    check_eq("abort_rspy", bus.rspY, 32'h0);
    check_eq("abort_rspc", bus.rspControl, 32'h0);
    check_eq("abort_corex", bus.coreX, 32'h0);
    check_eq("abort_corec", bus.coreControl, 32'h0);
    check_eq("abort_grant", bus.grantId, 1'b0);
    step();
    #1;
    check_eq("abort_rspv2", bus.rspValid, 2'b00);

    // Randomized traffic; a losing requester stays pending into the next job.
    pending = 2'b00;
    for (int j = 0; j < 30; j++) begin
      v = pending | 2'($urandom_range(0, 3));
      if (v == 2'b00) v = 2'b01 << $urandom_range(0, 1);
      random_ops();
      run_job(v, $urandom_range(0, TO - 1), $urandom, $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), pending);
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    // Watchdog: no interrupt, response exactly TO WAIT cycles after WAIT entry.
    random_ops();
    drive_ops();
    bus.reqValid = 2'b10;
    step();
    bus.reqValid = 2'b00;
    step();
    for (int i = 0; i < TO; i++) begin
      check_eq("to_wait_rspv", bus.rspValid, 2'b00);
      step();
    end
    check_eq("to_rspv", bus.rspValid, 2'b10);
    check_eq("to_err", bus.rspError, 1'b1);
    check_eq("to_rspx", bus.rspX, 32'h0);
    check_eq("to_rspc", bus.rspControl, 32'h0);
    model_last = 1'b1;
    step();
    check_eq("to_idle", bus.busy, 1'b0);
    check_eq("to_err_hold", bus.rspError, 1'b1);
    random_ops();
    run_job(2'b11, 2, $urandom, $urandom, $urandom, $urandom, 1'b0, pending);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 The block SHALL have parameter p_WIDTH, default 32, giving the datapath and control word width.
REQ-002 The block SHALL have parameter p_TIMEOUT, default 64, giving the WAIT-state cycle limit, used only when CORDIC_ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reqValid  in  2  per-requester job request; bit n belongs to requester n
- reqReady  out  2  per-requester accept
- reqX, reqY, reqZ  in  2*p_WIDTH  signed operands; bits [p_WIDTH-1:0] belong to requester 0, upper half to requester 1
- reqControl  in  2*p_WIDTH  control words, same packing as the operands
- rspValid  out  2  one-cycle result pulse per requester
- rspX, rspY, rspZ  out  p_WIDTH  results, shared by both requesters and qualified by rspValid
- rspControl  out  p_WIDTH  captured core control output
- rspError  out  1  timeout flag, qualified by rspValid
- coreX, coreY, coreZ, coreControl  out  p_WIDTH  drive the core's xInput, yInput, zInput and controlRegisterInput
- coreXResult, coreYResult, coreZResult, coreControlResult  in  p_WIDTH  from the core's xResult, yResult, zResult and controlRegisterOutput
- coreInterrupt  in  1  core completion pulse
- busy  out  1  high whenever the state is not IDLE
- grantId  out  1  index of the requester currently or last granted

Function
REQ-005 The block SHALL implement the states IDLE, ISSUE, WAIT and RESPOND, and reset SHALL place it in IDLE.
REQ-006 In IDLE, reqReady SHALL be driven combinationally high for exactly the selected requester, and SHALL be 0 in every other state.
REQ-007 Selection SHALL follow these rules:
- only one requester valid: that requester is selected
- both valid: the requester other than lastGrant is selected
- lastGrant resets to 1, so requester 0 wins the first contention
REQ-008 A handshake (reqValid[n] & reqReady[n]) SHALL capture that requester's operands and control word, set grantId = n, and move IDLE -> ISSUE.
REQ-009 In ISSUE, for exactly one cycle:
- coreX/Y/Z SHALL carry the captured operands
- coreControl SHALL carry the captured control word with bit 0 (start) forced to 1
- the next state SHALL be WAIT
REQ-010 In WAIT, coreX/Y/Z and coreControl SHALL hold the captured values with bit 0 = 0.
REQ-011 In WAIT, coreInterrupt = 1 SHALL capture coreXResult, coreYResult, coreZResult and coreControlResult into rspX, rspY, rspZ and rspControl, and move to RESPOND.
REQ-012 coreInterrupt SHALL be ignored in IDLE, ISSUE and RESPOND.
REQ-013 In RESPOND, for one cycle:
- rspValid[grantId] SHALL be 1
- lastGrant SHALL be updated to grantId
- the next state SHALL be IDLE
REQ-014 rspX/Y/Z, rspControl and rspError SHALL hold their values until the next capture.
REQ-015 Minimum latency SHALL be: handshake in cycle 0; ISSUE in cycle 1; interrupt no earlier than cycle 2; rspValid in the cycle after the interrupt.
REQ-016 A request asserted while busy SHALL NOT be accepted, and SHALL be eligible in the first IDLE cycle.

Reset
REQ-017 On rst:
- all outputs, captured registers and counters SHALL be 0, except lastGrant = 1 and state = IDLE
- core control bit 0 SHALL be 0
REQ-018 rst asserted in ISSUE, WAIT or RESPOND SHALL abort the job with no rspValid pulse, and a later coreInterrupt SHALL be ignored.

Configuration
REQ-019 With CORDIC_ARB_TIMEOUT_EN defined:
- a counter SHALL clear on entry to WAIT and increment each WAIT cycle
- if it reaches p_TIMEOUT with no interrupt, the block SHALL go to RESPOND with rspError = 1 and rspX/Y/Z and rspControl = 0
- rspError SHALL be 0 on a normal completion
- an interrupt in the same cycle as the limit SHALL win, giving a normal completion
REQ-020 Without CORDIC_ARB_TIMEOUT_EN, WAIT SHALL persist until coreInterrupt, no counter SHALL exist, and rspError SHALL be tied to 0.

Verification
REQ-021 Single job: requester 0 sends x=0x4000_0000, y=0, z=0x2000_0000; the core model interrupts 5 cycles after start with results 0x1111_1111/0x2222_2222/0x0 -> rspValid = 2'b01 one cycle later with those values; start bit high exactly 1 cycle.
REQ-022 Contention after reset: both requesters valid in the same cycle -> requester 0 served first and requester 1 second; if both then request again, the order is 0, 1, 0, 1.
REQ-023 Request while busy: requester 1 asserts during requester 0's WAIT -> reqReady[1] stays 0 until IDLE, then requester 1 is accepted in the first IDLE cycle.
REQ-024 Stray interrupt: coreInterrupt pulsed in IDLE and in ISSUE -> no state change and no rspValid.
REQ-025 Reset mid-WAIT: rst for 1 cycle, then coreInterrupt -> no rspValid, all outputs 0, busy = 0.
REQ-026 Timeout (macro defined, p_TIMEOUT = 8): no interrupt -> rspValid with rspError = 1 exactly 8 WAIT cycles after entering WAIT; the block then accepts the next job normally.
